// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types and defaults for the 1-D convolution row engine
package pe_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_PSUM_WIDTH = 32;
  localparam int LEN_W          = 8;

  typedef enum logic [3:0] {
    IDLE, CLR, RD_F, CAP_F, RD_I, CAP_I, MAC, OUT, DONE
  } state_t;
endpackage

// File: rtl/pe_conv1d_row_if.sv
// rtl/pe_conv1d_row_if.sv - filter/ifmap FIFO read ports and psum stream
interface pe_conv1d_row_if #(
  parameter int DATA_WIDTH = pe_pkg::DEF_DATA_WIDTH,
  parameter int PSUM_WIDTH = pe_pkg::DEF_PSUM_WIDTH
);
  logic                  filt_rdy;
  logic                  filt_rd_en;
  logic                  filt_rd_inc;
  logic                  filt_rd_clr;
  logic [DATA_WIDTH-1:0] filt_data;
  logic                  if_rdy;
  logic                  if_rd_en;
  logic                  if_rd_inc;
  logic [DATA_WIDTH-1:0] if_data;
  logic [PSUM_WIDTH-1:0] psum_out;
  logic                  psum_valid;
  logic                  psum_ready;

  modport master (
    output filt_rd_en, filt_rd_inc, filt_rd_clr, if_rd_en, if_rd_inc, psum_out, psum_valid,
    input  filt_rdy, filt_data, if_rdy, if_data, psum_ready
  );

  modport slave (
    input  filt_rd_en, filt_rd_inc, filt_rd_clr, if_rd_en, if_rd_inc, psum_out, psum_valid,
    output filt_rdy, filt_data, if_rdy, if_data, psum_ready
  );
endinterface

// File: rtl/pe_mac.sv
// rtl/pe_mac.sv - signed multiply with wrapping accumulate, cleared on the first tap
module pe_mac
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PSUM_WIDTH = DEF_PSUM_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         first,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic        [PSUM_WIDTH-1:0] acc
);
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic        [PSUM_WIDTH-1:0]   prod_ext;

  assign prod     = a * b;
  assign prod_ext = PSUM_WIDTH'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= first ? prod_ext : acc + prod_ext;
    end
  end
endmodule

// File: rtl/pe_conv1d_row.sv
// rtl/pe_conv1d_row.sv - row-stationary 1-D convolution engine: loads filter, slides
// an S-wide ifmap window and streams one psum per output position.
module pe_conv1d_row
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PSUM_WIDTH = DEF_PSUM_WIDTH,
  parameter int FILT_SIZE  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] ifmap_len,
  pe_conv1d_row_if.master  bus,
  output logic             busy,
  output logic             done
);
  localparam int               KW     = $clog2(FILT_SIZE);
  localparam logic [KW-1:0]    K_LAST = KW'(FILT_SIZE - 1);
  localparam logic [LEN_W-1:0] S_LEN  = LEN_W'(FILT_SIZE);

  state_t                       state;
  logic [LEN_W-1:0]             len;
  logic [LEN_W-1:0]             o_cnt;
  logic [KW-1:0]                f_cnt;
  logic [KW-1:0]                i_cnt;
  logic [KW-1:0]                k;
  logic signed [DATA_WIDTH-1:0] filt_reg [FILT_SIZE];
  logic signed [DATA_WIDTH-1:0] win      [FILT_SIZE];
  logic                         clr_q;
  logic                         valid_q;
  logic [PSUM_WIDTH-1:0]        acc;

  // Read enables follow rdy combinationally so the word lands exactly in the CAP state.
  assign bus.filt_rd_en  = (state == RD_F) && bus.filt_rdy;
  assign bus.filt_rd_inc = bus.filt_rd_en;
  assign bus.if_rd_en    = (state == RD_I) && bus.if_rdy;
  assign bus.if_rd_inc   = bus.if_rd_en;
  assign bus.filt_rd_clr = clr_q;
  assign bus.psum_valid  = valid_q;
  assign bus.psum_out    = acc;

  pe_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .PSUM_WIDTH(PSUM_WIDTH)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .en   (state == MAC),
    .first(k == '0),
    .a    (filt_reg[k]),
    .b    (win[k]),
    .acc  (acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      len     <= '0;
      o_cnt   <= '0;
      f_cnt   <= '0;
      i_cnt   <= '0;
      k       <= '0;
      clr_q   <= 1'b0;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int n = 0; n < FILT_SIZE; n++) begin
        filt_reg[n] <= '0;
        win[n]      <= '0;
      end
    end else begin
      case (state)
        IDLE: if (start) begin
          len   <= ifmap_len;
          o_cnt <= '0;
          f_cnt <= '0;
          i_cnt <= '0;
          k     <= '0;
          clr_q <= 1'b1;
          busy  <= 1'b1;
          state <= CLR;
        end
        CLR: begin
          clr_q <= 1'b0;
          if (len < S_LEN) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= RD_F;
          end
        end
        RD_F: if (bus.filt_rdy) state <= CAP_F;
        CAP_F: begin
          filt_reg[f_cnt] <= bus.filt_data;
          if (f_cnt == K_LAST) begin
            f_cnt <= '0;
            state <= RD_I;
          end else begin
            f_cnt <= f_cnt + 1'b1;
            state <= RD_F;
          end
        end
        RD_I: if (bus.if_rdy) state <= CAP_I;
        CAP_I: begin
          for (int n = 0; n < FILT_SIZE - 1; n++) win[n] <= win[n+1];
          win[FILT_SIZE-1] <= bus.if_data;
          // i_cnt saturates at S-1: once the window is primed every capture yields a psum.
          if (i_cnt != K_LAST) begin
            i_cnt <= i_cnt + 1'b1;
            state <= RD_I;
          end else begin
            k     <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          if (k == K_LAST) begin
            k       <= '0;
            valid_q <= 1'b1;
            state   <= OUT;
          end else begin
            k <= k + 1'b1;
          end
        end
        OUT: if (bus.psum_ready) begin
          valid_q <= 1'b0;
          o_cnt   <= o_cnt + 1'b1;
          if (o_cnt == len - S_LEN) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= RD_I;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_conv1d_row.sv
// tb/tb_pe_conv1d_row.sv - directed self-checking bench with FIFO models and psum monitor
module tb_pe_conv1d_row;
  import pe_pkg::*;

  localparam int DW = 16;
  localparam int PW = 32;
  localparam int S  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] ifmap_len = '0;
  logic             busy;
  logic             done;

  pe_conv1d_row_if #(.DATA_WIDTH(DW), .PSUM_WIDTH(PW)) bus ();

  pe_conv1d_row #(.DATA_WIDTH(DW), .PSUM_WIDTH(PW), .FILT_SIZE(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ifmap_len(ifmap_len),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fmem [0:7];
  logic [DW-1:0] imem [0:15];
  int            fptr = 0;
  int            iptr = 0;
  int            ilen = 0;
  logic          rewind = 1'b0;
  logic          if_gate = 1'b1;
  logic          rdy_gate = 1'b1;
  logic          rand_mode = 1'b0;

  assign bus.filt_rdy   = (fptr < S);
  assign bus.if_rdy     = (iptr < ilen) && if_gate;
  assign bus.psum_ready = rdy_gate;

  // FIFO models: one-cycle read latency, output 0 when not read
  always @(posedge clk) begin
    if (bus.filt_rd_clr) fptr <= 0;
    else if (bus.filt_rd_en) fptr <= fptr + 1;
    if (rewind) iptr <= 0;
    else if (bus.if_rd_en) iptr <= iptr + 1;
    bus.filt_data <= bus.filt_rd_en ? fmem[fptr[2:0]] : '0;
    bus.if_data   <= bus.if_rd_en ? imem[iptr[3:0]] : '0;
  end

  always @(posedge clk) begin
    #1;
    if (rand_mode) begin
      if_gate  = 1'($urandom_range(0, 1));
      rdy_gate = 1'($urandom_range(0, 1));
    end else begin
      if_gate  = 1'b1;
      rdy_gate = 1'b1;
    end
  end

  logic [PW-1:0] got [$];
  logic [PW-1:0] exp_q [$];
  int            cyc = 0;
  int            first_cyc = -1;
  int            done_cyc = -1;
  int            n_done = 0;
  int            n_clr = 0;
  int            n_rd = 0;
  int            viol_stable = 0;
  int            viol_rd = 0;
  int            viol_clr = 0;
  logic          pend = 1'b0;
  logic [PW-1:0] pend_val = '0;

  always @(negedge clk) begin
    if (start) cyc = 0;
    else cyc++;
    if (bus.psum_valid && first_cyc < 0) first_cyc = cyc;
    if (pend && (!bus.psum_valid || bus.psum_out != pend_val)) viol_stable++;
    if (bus.psum_valid && bus.psum_ready) got.push_back(bus.psum_out);
    pend     = bus.psum_valid && !bus.psum_ready;
    pend_val = bus.psum_out;
    if (bus.if_rd_en && !bus.if_rdy) viol_rd++;
    if (bus.filt_rd_en && !bus.filt_rdy) viol_rd++;
    if (bus.filt_rd_clr && (bus.filt_rd_en || bus.if_rd_en)) viol_clr++;
    if (bus.filt_rd_clr) n_clr++;
    if (bus.filt_rd_en || bus.if_rd_en) n_rd++;
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_count"}, longint'(got.size()), longint'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_psum%0d", tag, i), longint'(got[i]), longint'(exp_q[i]));
  endtask

  task automatic launch(input int w);
    @(posedge clk);
    #1;
    got.delete();
    first_cyc = -1;
    done_cyc  = -1;
    n_done    = 0;
    n_clr     = 0;
    n_rd      = 0;
    pend      = 1'b0;
    ilen      = w;
    ifmap_len = LEN_W'(w);
    rewind    = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    rewind = 1'b0;
  endtask

  task automatic run_row(input string tag, input int w);
    launch(w);
    for (int i = 0; i < 3000 && n_done == 0; i++) @(posedge clk);
    check({tag, "_done_seen"}, longint'(n_done != 0), 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic load_basic();
    fmem[0] = 16'd1; fmem[1] = 16'd2; fmem[2] = 16'd3;
    imem[0] = 16'd1; imem[1] = 16'd2; imem[2] = 16'd3; imem[3] = 16'd4; imem[4] = 16'd5;
    exp_q = '{32'd14, 32'd20, 32'd26};
  endtask

  initial begin
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", bus.psum_valid, 0);
    check("rst_psum", bus.psum_out, 0);
    check("rst_clr", bus.filt_rd_clr, 0);
    check("rst_rd_en", longint'(bus.filt_rd_en | bus.if_rd_en), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    load_basic();
    run_row("basic", 5);
    check_seq("basic");
    check("basic_first_valid_cyc", first_cyc, 17);
    check("basic_done_cyc", done_cyc, 30);
    check("basic_done_pulses", n_done, 1);
    check("basic_clr_pulses", n_clr, 1);

    // Second row reuses the filter through the rewound pointer
    imem[0] = 16'd5; imem[1] = 16'd4; imem[2] = 16'd3; imem[3] = 16'd2; imem[4] = 16'd1;
    exp_q = '{32'd22, 32'd16, 32'd10};
    run_row("reuse", 5);
    check_seq("reuse");
    check("reuse_clr_pulses", n_clr, 1);

    fmem[0] = 16'hFFFF; fmem[1] = 16'd2; fmem[2] = 16'hFFFD;
    imem[0] = 16'h8000; imem[1] = 16'd1; imem[2] = 16'd0;
    exp_q = '{32'd32770};
    run_row("signed", 3);
    check_seq("signed");

    fmem[0] = 16'h8000; fmem[1] = 16'h8000; fmem[2] = 16'h8000;
    imem[0] = 16'h8000; imem[1] = 16'h8000; imem[2] = 16'h8000;
    exp_q = '{32'hC000_0000};
    run_row("wrap", 3);
    check_seq("wrap");

    load_basic();
    rand_mode = 1'b1;
    run_row("bp", 5);
    rand_mode = 1'b0;
    check_seq("bp");
    check("bp_done_pulses", n_done, 1);

    exp_q.delete();
    run_row("degen", 2);
    check_seq("degen");
    check("degen_reads", n_rd, 0);
    check("degen_done_cyc", done_cyc, 2);
    check("degen_clr_pulses", n_clr, 1);

    // Reset lands in cycle 21, the middle of the second psum's MAC
    load_basic();
    launch(5);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", bus.psum_valid, 0);
    check("mid_rst_psum", bus.psum_out, 0);
    check("mid_rst_rd_en", longint'(bus.filt_rd_en | bus.if_rd_en | bus.filt_rd_clr), 0);
    check("mid_rst_psums_before", got.size(), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mid_rst_no_done", n_done, 0);
    check("mid_rst_idle", busy, 0);
    run_row("after_rst", 5);
    check_seq("after_rst");

    check("stable_violations", viol_stable, 0);
    check("rd_without_rdy", viol_rd, 0);
    check("clr_with_rd_en", viol_clr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
